// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding and timing defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAIT = 2'd1,
    S_PKT  = 2'd2
  } rx_state_e;

  localparam int unsigned CLOCKS_PER_BIT = 868;
  // Ten bit times of silence close a packet.
  localparam int unsigned IDLE_TIMEOUT_CLKS_DEFAULT = 10 * CLOCKS_PER_BIT;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through read port; pointers carry a wrap bit so full and
// empty are distinguished without a separate counter.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
  logic            empty;
  logic            rd_en;
  logic            wr_do;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign rd_valid = !empty;
  assign rd_en    = rd_ready && !empty && !flush;
  assign wr_do    = wr_en && !flush;
  // Head byte is forced to zero while empty so the port idles at a defined value.
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the receiver, buffers good bytes, counts framing errors and
// closes packets after a period of line idle.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ADDR_W            = 4,
  parameter int unsigned IDLE_TIMEOUT_CLKS = IDLE_TIMEOUT_CLKS_DEFAULT,
  parameter int unsigned TIMER_W           = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              clr_status,
  output logic              rx_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [7:0]        err_count,
  output logic              pkt_end,
  output logic              busy
);

  rx_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pkt_end_q, pkt_end_d;
  logic               rx_en_q;
  logic               overflow_q, overflow_d;
  logic [7:0]         err_q, err_d, err_base;

  logic wr_req, err_evt, activity, fifo_full, fifo_wr, drop, timeout;

  // A framing error in the same cycle as rx_valid disqualifies the byte.
  assign wr_req   = rx_en_q && rx_valid && !rx_frame_err;
  assign err_evt  = rx_en_q && rx_frame_err;
  assign activity = rx_en_q && (rx_valid || rx_frame_err);
  // When full, a same-cycle read frees the head slot so the new byte still fits.
  assign fifo_wr  = wr_req && (!fifo_full || rd_ready);
  assign drop     = wr_req && fifo_full && !rd_ready && !flush;
  assign timeout  = (timer_q == TIMER_W'(IDLE_TIMEOUT_CLKS - 1));

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (fifo_wr),
    .wr_data  (rx_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OFF;
      timer_q   <= '0;
      pkt_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pkt_end_q <= pkt_end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    pkt_end_d = 1'b0;
    if (!en) begin
      state_d = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF:  state_d = S_WAIT;
        S_WAIT: if (wr_req && !flush) state_d = S_PKT;
        S_PKT: begin
          if (flush) begin
            state_d = S_WAIT;
          end else if (activity) begin
            timer_d = '0;
          end else if (timeout) begin
            state_d   = S_WAIT;
            pkt_end_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == S_PKT);
    pkt_end = pkt_end_q;
  end

  always_comb begin
    overflow_d = clr_status ? 1'b0 : overflow_q;
    if (drop) overflow_d = 1'b1;
    err_base = clr_status ? 8'h00 : err_q;
    err_d    = (err_evt && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      rx_en_q    <= en;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign rx_en     = rx_en_q;
  assign overflow  = overflow_q;
  assign err_count = err_q;

endmodule
